// File: rtl/instr_buffer.sv
// Instruction buffer: circular FIFO between fetch and decode.
// Takes up to FETCH_WIDTH instructions per cycle and shows the DECODE_WIDTH oldest entries.
// Each instr_info_o lane is InfoW bits wide.
// Lane layout, LSB first: pc, instr, excp, excp_num[6:0], valid.
module instr_buffer #(
    parameter int unsigned FETCH_WIDTH  = 4,
    parameter int unsigned DECODE_WIDTH = 2,
    parameter int unsigned BUFFER_DEPTH = 16,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              flush_i,
    input  logic [FETCH_WIDTH-1:0]                            fetch_valid_i,
    input  logic [FETCH_WIDTH*ADDR_WIDTH-1:0]                 fetch_pc_i,
    input  logic [FETCH_WIDTH*DATA_WIDTH-1:0]                 fetch_instr_i,
    input  logic [FETCH_WIDTH-1:0]                            fetch_excp_i,
    input  logic [FETCH_WIDTH*7-1:0]                          fetch_excp_num_i,
    output logic                                              frontend_stallreq_o,
    output logic [DECODE_WIDTH*(ADDR_WIDTH+DATA_WIDTH+9)-1:0] instr_info_o,
    input  logic [DECODE_WIDTH-1:0]                           decode_accept_i
);

    localparam int unsigned PtrW  = $clog2(BUFFER_DEPTH);
    localparam int unsigned CntW  = $clog2(BUFFER_DEPTH + 1);
    localparam int unsigned InfoW = ADDR_WIDTH + DATA_WIDTH + 9;

    logic [ADDR_WIDTH-1:0] pc_q       [BUFFER_DEPTH];
    logic [DATA_WIDTH-1:0] instr_q    [BUFFER_DEPTH];
    logic                  excp_q     [BUFFER_DEPTH];
    logic [6:0]            excp_num_q [BUFFER_DEPTH];

    logic [PtrW-1:0]         head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0]         count_q, count_d;
    logic [CntW-1:0]         free, push_n, pop_n, push_amt;
    logic                    push_en, run_push, run_pop;
    logic [DECODE_WIDTH-1:0] lane_valid;

    // The stall decision uses only the registered count, so a same-cycle pop never frees space.
    assign free                = CntW'(BUFFER_DEPTH) - count_q;
    assign frontend_stallreq_o = free < CntW'(FETCH_WIDTH);
    assign push_en             = !flush_i && !frontend_stallreq_o;
    assign push_amt            = push_en ? push_n : '0;

    // Count the leading valid fetch lanes; lanes after the first hole are dropped.
    always_comb begin
        push_n   = '0;
        run_push = 1'b1;
        for (int unsigned k = 0; k < FETCH_WIDTH; k++) begin
            if (run_push && fetch_valid_i[k]) begin
                push_n = push_n + CntW'(1);
            end else begin
                run_push = 1'b0;
            end
        end
    end

    // Drive the head entries from registers only; lanes past count are all zero.
    always_comb begin
        instr_info_o = '0;
        lane_valid   = '0;
        for (int unsigned k = 0; k < DECODE_WIDTH; k++) begin
            if (CntW'(k) < count_q) begin
                lane_valid[k] = 1'b1;
                instr_info_o[k*InfoW +: InfoW] = {1'b1,
                                                  excp_num_q[head_q + PtrW'(k)],
                                                  excp_q[head_q + PtrW'(k)],
                                                  instr_q[head_q + PtrW'(k)],
                                                  pc_q[head_q + PtrW'(k)]};
            end
        end
    end

    // Retire the leading run of lanes that are both valid and accepted.
    always_comb begin
        pop_n   = '0;
        run_pop = 1'b1;
        for (int unsigned k = 0; k < DECODE_WIDTH; k++) begin
            if (run_pop && lane_valid[k] && decode_accept_i[k]) begin
                pop_n = pop_n + CntW'(1);
            end else begin
                run_pop = 1'b0;
            end
        end
    end

    // Advance the pointers and the count.
    always_comb begin
        head_d  = head_q + PtrW'(pop_n);
        tail_d  = tail_q + PtrW'(push_amt);
        count_d = count_q + push_amt - pop_n;
    end

    // Control state; reset and flush both empty the buffer and drop any same-cycle push or pop.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Write the accepted fetch lanes at tail+k; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (!rst && push_en) begin
            for (int unsigned k = 0; k < FETCH_WIDTH; k++) begin
                if (CntW'(k) < push_n) begin
                    pc_q[tail_q + PtrW'(k)]       <= fetch_pc_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                    instr_q[tail_q + PtrW'(k)]    <= fetch_instr_i[k*DATA_WIDTH +: DATA_WIDTH];
                    excp_q[tail_q + PtrW'(k)]     <= fetch_excp_i[k];
                    excp_num_q[tail_q + PtrW'(k)] <= fetch_excp_num_i[k*7 +: 7];
                end
            end
        end
    end

    // Occupancy bounds hold, and a fetch_valid_i with holes gets a warning.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (count_q <= CntW'(BUFFER_DEPTH))
                else $error("instr_buffer: count above depth");
            assert (pop_n <= count_q)
                else $error("instr_buffer: pop exceeds count");
            assert ((fetch_valid_i >> push_n) == '0)
                else $warning("instr_buffer: non-prefix fetch_valid_i");
        end
    end

endmodule

// File: tb/tb_instr_buffer.sv
// Directed self-checking bench for instr_buffer with the default parameters.
module tb_instr_buffer;

    localparam int InfoW = 73;
    localparam logic [31:0] Base = 32'h1c00_0000;

    logic         clk;
    logic         rst;
    logic         flush;
    logic [3:0]   fetch_valid;
    logic [127:0] fetch_pc;
    logic [127:0] fetch_instr;
    logic [3:0]   fetch_excp;
    logic [27:0]  fetch_excp_num;
    logic         stall;
    logic [145:0] info;
    logic [1:0]   accept;

    int tests_run;
    int tests_failed;

    instr_buffer dut (
        .clk                (clk),
        .rst                (rst),
        .flush_i            (flush),
        .fetch_valid_i      (fetch_valid),
        .fetch_pc_i         (fetch_pc),
        .fetch_instr_i      (fetch_instr),
        .fetch_excp_i       (fetch_excp),
        .fetch_excp_num_i   (fetch_excp_num),
        .frontend_stallreq_o(stall),
        .instr_info_o       (info),
        .decode_accept_i    (accept)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic li_valid(input int k);
        return info[k*InfoW + 72];
    endfunction
    function automatic logic [31:0] li_pc(input int k);
        return info[k*InfoW +: 32];
    endfunction
    function automatic logic [31:0] li_instr(input int k);
        return info[k*InfoW + 32 +: 32];
    endfunction
    function automatic logic li_excp(input int k);
        return info[k*InfoW + 64];
    endfunction
    function automatic logic [6:0] li_num(input int k);
        return info[k*InfoW + 65 +: 7];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_group(input logic [3:0] v, input logic [31:0] pc0);
        fetch_valid    = v;
        fetch_excp     = '0;
        fetch_excp_num = '0;
        for (int k = 0; k < 4; k++) begin
            fetch_pc[k*32 +: 32]    = pc0 + 32'(4 * k);
            fetch_instr[k*32 +: 32] = (pc0 + 32'(4 * k)) ^ 32'hA5A5_0000;
        end
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        flush       = 1'b0;
        accept      = '0;
        set_group(4'b0000, 32'h0);
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        flush       = 1'b0;
        accept      = 2'b11;
        set_group(4'b1111, Base);
        step();
        rst = 1'b0;
        accept = '0;
        set_group(4'b0000, 32'h0);
        tests_run++;
        if (info !== '0) begin
            tests_failed++;
            $display("FAIL reset_info got=%h want=0", info);
        end
        tests_run++;
        if (stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_stall got=%b want=0", stall);
        end
        tests_run++;
        if (dut.count_q !== 5'd0) begin
            tests_failed++;
            $display("FAIL reset_count got=%0d want=0", dut.count_q);
        end
    endtask

    task automatic test_push_basic();
        do_reset();
        set_group(4'b1111, Base);
        step();
        set_group(4'b0000, 32'h0);
        tests_run++;
        if (li_valid(0) !== 1'b1 || li_pc(0) !== Base) begin
            tests_failed++;
            $display("FAIL push_lane0 got v=%b pc=%h want v=1 pc=%h", li_valid(0), li_pc(0), Base);
        end
        tests_run++;
        if (li_valid(1) !== 1'b1 || li_pc(1) !== Base + 32'h4) begin
            tests_failed++;
            $display("FAIL push_lane1 got v=%b pc=%h want v=1 pc=%h", li_valid(1), li_pc(1),
                     Base + 32'h4);
        end
        tests_run++;
        if (dut.count_q !== 5'd4 || stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL push_count got count=%0d stall=%b want 4/0", dut.count_q, stall);
        end
    endtask

    task automatic test_pop();
        // Continues from test_push_basic: four entries queued.
        accept = 2'b11;
        step();
        tests_run++;
        if (li_pc(0) !== Base + 32'h8 || li_pc(1) !== Base + 32'hc || dut.count_q !== 5'd2) begin
            tests_failed++;
            $display("FAIL pop_first got pc=%h,%h count=%0d want %h,%h count=2", li_pc(0),
                     li_pc(1), dut.count_q, Base + 32'h8, Base + 32'hc);
        end
        step();
        accept = '0;
        tests_run++;
        if (info !== '0 || dut.count_q !== 5'd0) begin
            tests_failed++;
            $display("FAIL pop_empty got info=%h count=%0d want 0/0", info, dut.count_q);
        end
        // Accepting an empty buffer has no effect.
        accept = 2'b11;
        step();
        accept = '0;
        tests_run++;
        if (dut.count_q !== 5'd0 || info !== '0) begin
            tests_failed++;
            $display("FAIL pop_on_empty got count=%0d want 0", dut.count_q);
        end
        // Accept only on lane 1 must not pop anything.
        do_reset();
        set_group(4'b1111, Base);
        step();
        set_group(4'b0000, 32'h0);
        accept = 2'b10;
        step();
        accept = '0;
        tests_run++;
        if (dut.count_q !== 5'd4 || li_pc(0) !== Base) begin
            tests_failed++;
            $display("FAIL pop_nonprefix got count=%0d pc=%h want 4 pc=%h", dut.count_q,
                     li_pc(0), Base);
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int g = 0; g < 4; g++) begin
            set_group(4'b1111, Base + 32'(16 * g));
            step();
        end
        tests_run++;
        if (dut.count_q !== 5'd16 || stall !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_count got count=%0d stall=%b want 16/1", dut.count_q, stall);
        end
        set_group(4'b1111, 32'hdead_0000);
        step();
        set_group(4'b0000, 32'h0);
        tests_run++;
        if (dut.count_q !== 5'd16 || li_pc(0) !== Base) begin
            tests_failed++;
            $display("FAIL full_drop got count=%0d pc=%h want 16 pc=%h", dut.count_q, li_pc(0),
                     Base);
        end
        accept = 2'b11;
        step();
        tests_run++;
        if (dut.count_q !== 5'd14 || stall !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_pop1 got count=%0d stall=%b want 14/1", dut.count_q, stall);
        end
        step();
        accept = '0;
        tests_run++;
        if (dut.count_q !== 5'd12 || stall !== 1'b0 || li_pc(0) !== Base + 32'h10) begin
            tests_failed++;
            $display("FAIL full_pop2 got count=%0d stall=%b pc=%h want 12/0 pc=%h", dut.count_q,
                     stall, li_pc(0), Base + 32'h10);
        end
    endtask

    task automatic test_back_to_back();
        int sent;
        int popped;
        int mc;
        int cyc;
        int pn;
        int qn;
        logic exp_stall;
        do_reset();
        sent   = 0;
        popped = 0;
        mc     = 0;
        cyc    = 0;
        while ((sent < 60 || mc > 0) && cyc < 200) begin
            exp_stall = (16 - mc) < 4;
            tests_run++;
            if (stall !== exp_stall) begin
                tests_failed++;
                $display("FAIL steady_stall cyc=%0d got=%b want=%b", cyc, stall, exp_stall);
            end
            for (int k = 0; k < 2; k++) begin
                tests_run++;
                if (li_valid(k) !== (k < mc) ||
                    (k < mc && li_pc(k) !== Base + 32'(4 * (popped + k)))) begin
                    tests_failed++;
                    $display("FAIL steady_lane%0d cyc=%0d got v=%b pc=%h want v=%b pc=%h", k,
                             cyc, li_valid(k), li_pc(k), k < mc, Base + 32'(4 * (popped + k)));
                end
            end
            pn = (!exp_stall && sent < 60) ? 4 : 0;
            qn = (mc >= 2) ? 2 : mc;
            if (pn != 0) set_group(4'b1111, Base + 32'(4 * sent));
            else set_group(4'b0000, 32'h0);
            accept = 2'b11;
            step();
            sent   += pn;
            popped += qn;
            mc     = mc + pn - qn;
            cyc++;
        end
        set_group(4'b0000, 32'h0);
        accept = '0;
        tests_run++;
        if (cyc >= 200 || popped != 60 || dut.count_q !== 5'd0) begin
            tests_failed++;
            $display("FAIL steady_drain got cyc=%0d popped=%0d count=%0d want <200/60/0", cyc,
                     popped, dut.count_q);
        end
    endtask

    task automatic test_flush();
        do_reset();
        set_group(4'b1111, Base);
        step();
        set_group(4'b1111, Base + 32'h10);
        accept = 2'b11;
        step();
        tests_run++;
        if (dut.count_q !== 5'd6) begin
            tests_failed++;
            $display("FAIL flush_setup got count=%0d want 6", dut.count_q);
        end
        flush = 1'b1;
        set_group(4'b1111, Base + 32'h20);
        accept = 2'b11;
        step();
        flush = 1'b0;
        accept = '0;
        set_group(4'b0000, 32'h0);
        tests_run++;
        if (dut.count_q !== 5'd0 || info !== '0 || stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_clear got count=%0d info=%h stall=%b want 0/0/0", dut.count_q,
                     info, stall);
        end
        set_group(4'b0001, 32'h0000_2000);
        step();
        set_group(4'b0000, 32'h0);
        tests_run++;
        if (li_valid(0) !== 1'b1 || li_pc(0) !== 32'h0000_2000 || li_valid(1) !== 1'b0 ||
            dut.count_q !== 5'd1) begin
            tests_failed++;
            $display("FAIL flush_repush got v0=%b pc=%h v1=%b count=%0d want 1/00002000/0/1",
                     li_valid(0), li_pc(0), li_valid(1), dut.count_q);
        end
    endtask

    task automatic test_fields();
        do_reset();
        set_group(4'b1111, Base);
        fetch_instr[0*32 +: 32]  = 32'h5000_0400;
        fetch_instr[1*32 +: 32]  = 32'h5400_0800;
        fetch_instr[2*32 +: 32]  = 32'h0280_0000;
        fetch_instr[3*32 +: 32]  = 32'h0340_0000;
        fetch_excp               = 4'b0100;
        fetch_excp_num[2*7 +: 7] = 7'h08;
        step();
        set_group(4'b0000, 32'h0);
        tests_run++;
        if (li_instr(0) !== 32'h5000_0400 || li_instr(1) !== 32'h5400_0800) begin
            tests_failed++;
            $display("FAIL fields_instr got %h,%h want 50000400,54000800", li_instr(0),
                     li_instr(1));
        end
        tests_run++;
        if (li_excp(0) !== 1'b0 || li_excp(1) !== 1'b0 || li_num(0) !== 7'h0 ||
            li_num(1) !== 7'h0) begin
            tests_failed++;
            $display("FAIL fields_noexcp got excp=%b,%b num=%h,%h want 0", li_excp(0),
                     li_excp(1), li_num(0), li_num(1));
        end
        accept = 2'b11;
        step();
        accept = '0;
        tests_run++;
        if (li_excp(0) !== 1'b1 || li_num(0) !== 7'h08 || li_instr(0) !== 32'h0280_0000) begin
            tests_failed++;
            $display("FAIL fields_excp got excp=%b num=%h instr=%h want 1/08/02800000",
                     li_excp(0), li_num(0), li_instr(0));
        end
        tests_run++;
        if (li_excp(1) !== 1'b0 || li_num(1) !== 7'h0 || li_instr(1) !== 32'h0340_0000) begin
            tests_failed++;
            $display("FAIL fields_lane3 got excp=%b num=%h instr=%h want 0/00/03400000",
                     li_excp(1), li_num(1), li_instr(1));
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_push_basic();
        test_pop();
        test_full();
        test_back_to_back();
        test_flush();
        test_fields();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
